// File: rtl/entrada_pkg.sv
// entrada_pkg: shared definitions for the IN-instruction input unit.
//   estado_t        : FSM state encoding (code 2'd3 is illegal, recovers to OCIOSO)
//   DEBOUNCE_SYNTH  : debounce length for the board clock
//   DEBOUNCE_SIM    : short debounce length for simulation
package entrada_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESPERA  = 2'd1,
    CAPTURA = 2'd2
  } estado_t;

  localparam int unsigned DEBOUNCE_SYNTH = 50000;
  localparam int unsigned DEBOUNCE_SIM   = 4;

endpackage

// File: rtl/entrada_debounce_botao.sv
// debounce_botao: synchronizer, debouncer and press detector for an
// active-low push button.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (level forced to released = 1)
//   botao_i  : raw button, asynchronous, active-low
//   nivel_o  : debounced button level (1 = released)
//   aperto_o : one-cycle pulse, high in the cycle whose closing edge moves
//              the debounced level from 1 to 0
module debounce_botao
  import entrada_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic botao_i,
  output logic nivel_o,
  output logic aperto_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic          nivel_q;
  logic          nivel_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          vira;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle;
  // any agreeing cycle restarts the count.
  always_comb begin
    vira    = (sync2_q != nivel_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    nivel_d = vira ? ~nivel_q : nivel_q;
    if ((sync2_q == nivel_q) || vira) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      nivel_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= botao_i;
      sync2_q <= sync1_q;
      nivel_q <= nivel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign nivel_o = nivel_q;
  // Press edge is taken from the flip decision rather than a delayed copy of
  // the level, so the FSM sees it one cycle earlier.
  assign aperto_o = vira & nivel_q;

endmodule

// File: rtl/entrada.sv
// entrada: input unit for the IN instruction. Stalls the processor until
// the user confirms the switch value with the push button, then places the
// extended switch value on the write-back bus.
//   clock      : system clock
//   res        : synchronous active-high reset
//   in         : high while an IN instruction executes
//   chaves     : board switches (quasi-static)
//   confirma   : raw push button, active-low, asynchronous
//   numero     : captured, extended switch value (registered, held)
//   pronto     : one-cycle pulse when a value has been captured
//   halt       : combinational stall request to the PC/control unit
//   aguardando : registered status LED, high while waiting for the user
module entrada
  import entrada_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned SIGN_EXT        = 0,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_SYNTH
) (
  input  logic                  clock,
  input  logic                  res,
  input  logic                  in,
  input  logic [SW_WIDTH-1:0]   chaves,
  input  logic                  confirma,
  output logic [DATA_WIDTH-1:0] numero,
  output logic                  pronto,
  output logic                  halt,
  output logic                  aguardando
);

  localparam int unsigned EXT_W = DATA_WIDTH - SW_WIDTH;

  estado_t               estado_q;
  estado_t               estado_d;
  logic [DATA_WIDTH-1:0] numero_q;
  logic [DATA_WIDTH-1:0] numero_d;
  logic                  aguardando_q;
  logic [DATA_WIDTH-1:0] estendido;
  logic                  aperto;
  // Only the press edge matters here; the debounced level itself is unused.
  logic                  botao_nivel_unused;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_botao (
    .clk_i   (clock),
    .rst_i   (res),
    .botao_i (confirma),
    .nivel_o (botao_nivel_unused),
    .aperto_o(aperto)
  );

  always_comb begin
    estendido = {{EXT_W{(SIGN_EXT != 0) & chaves[SW_WIDTH-1]}}, chaves};
  end

  // State register
  always_ff @(posedge clock) begin
    if (res) begin
      estado_q     <= OCIOSO;
      numero_q     <= '0;
      aguardando_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      numero_q     <= numero_d;
      aguardando_q <= (estado_d == ESPERA);
    end
  end

  // Next state; presses seen in OCIOSO are dropped on purpose, and a falling
  // in during ESPERA wins over a simultaneous press.
  always_comb begin
    estado_d = OCIOSO;
    numero_d = numero_q;
    case (estado_q)
      OCIOSO: begin
        estado_d = in ? ESPERA : OCIOSO;
      end
      ESPERA: begin
        if (!in) begin
          estado_d = OCIOSO;
        end else if (aperto) begin
          estado_d = CAPTURA;
          numero_d = estendido;
        end else begin
          estado_d = ESPERA;
        end
      end
      CAPTURA: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // Outputs
  always_comb begin
    pronto     = (estado_q == CAPTURA);
    halt       = ((estado_q == OCIOSO) && in) || (estado_q == ESPERA);
    numero     = numero_q;
    aguardando = aguardando_q;
  end

endmodule

// File: tb/tb_entrada.sv
module tb_entrada;
  import entrada_pkg::*;

  logic        clock;
  logic        res;
  logic        in;
  logic [15:0] chaves;
  logic        confirma;

  logic [31:0] numero0, numero1;
  logic        pronto0, pronto1, halt0, halt1, aguard0, aguard1;

  int errors = 0;
  int checks = 0;
  int npronto = 0;

  entrada #(
    .DATA_WIDTH(32), .SW_WIDTH(16), .SIGN_EXT(0), .DEBOUNCE_CYCLES(DEBOUNCE_SIM)
  ) dut0 (
    .clock(clock), .res(res), .in(in), .chaves(chaves), .confirma(confirma),
    .numero(numero0), .pronto(pronto0), .halt(halt0), .aguardando(aguard0)
  );

  entrada #(
    .DATA_WIDTH(32), .SW_WIDTH(16), .SIGN_EXT(1), .DEBOUNCE_CYCLES(DEBOUNCE_SIM)
  ) dut1 (
    .clock(clock), .res(res), .in(in), .chaves(chaves), .confirma(confirma),
    .numero(numero1), .pronto(pronto1), .halt(halt1), .aguardando(aguard1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each; counts pronto pulses.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (pronto0 === 1'b1) npronto++;
    end
  endtask

  // Full IN instruction: press lands 6 edges after the button goes low.
  task automatic in_cycle(input logic [15:0] sw, input string tag);
    chaves = sw;
    in = 1'b1;
    tick(1);
    chk({tag, "_espera_aguard"}, {31'd0, aguard0}, 32'd1);
    confirma = 1'b0;
    tick(5);
    chk({tag, "_pronto_early"}, {31'd0, pronto0}, 32'd0);
    chk({tag, "_halt_wait"}, {31'd0, halt0}, 32'd1);
    tick(1);
    chk({tag, "_pronto"}, {31'd0, pronto0}, 32'd1);
    chk({tag, "_halt_cap"}, {31'd0, halt0}, 32'd0);
    in = 1'b0;
    tick(1);
    chk({tag, "_pronto_1cyc"}, {31'd0, pronto0}, 32'd0);
    tick(3);
    confirma = 1'b1;
    tick(8);
  endtask

  initial begin
    res = 1'b1; in = 1'b0; chaves = 16'h0000; confirma = 1'b1;

    // 1. reset
    tick(2);
    chk("rst_numero", numero0, 32'h0);
    chk("rst_pronto", {31'd0, pronto0}, 32'd0);
    chk("rst_halt", {31'd0, halt0}, 32'd0);
    chk("rst_aguard", {31'd0, aguard0}, 32'd0);
    in = 1'b1;
    #1;
    chk("rst_halt_in", {31'd0, halt0}, 32'd1);
    tick(1);
    chk("rst_halt_in_hold", {31'd0, halt0}, 32'd1);
    chk("rst_aguard_in", {31'd0, aguard0}, 32'd0);
    res = 1'b0; in = 1'b0;
    #1;
    chk("rel_halt", {31'd0, halt0}, 32'd0);
    tick(1);
    chk("rel_idle_aguard", {31'd0, aguard0}, 32'd0);
    chk("rel_idle_halt", {31'd0, halt0}, 32'd0);

    // 2. basic capture
    in = 1'b1;
    #1;
    chk("t2_halt_first", {31'd0, halt0}, 32'd1);
    in_cycle(16'h002A, "t2");
    chk("t2_numero", numero0, 32'h0000002A);
    chk("t2_numero_sx", numero1, 32'h0000002A);

    // 3. extension
    in_cycle(16'hFFF6, "t3");
    chk("t3_zero_ext", numero0, 32'h0000FFF6);
    chk("t3_sign_ext", numero1, 32'hFFFFFFF6);

    // 4a. bouncy press
    chaves = 16'h0055;
    in = 1'b1;
    tick(1);
    npronto = 0;
    confirma = 1'b0; tick(1);
    confirma = 1'b1; tick(1);
    confirma = 1'b0; tick(1);
    confirma = 1'b1; tick(1);
    confirma = 1'b0; tick(12);
    chk("t4_one_pronto", npronto, 32'd1);
    chk("t4_numero", numero0, 32'h00000055);
    chk("t4_halt_rewait", {31'd0, halt0}, 32'd1);
    in = 1'b0;
    tick(1);
    confirma = 1'b1;
    tick(8);

    // 4b. press while idle is discarded
    chaves = 16'h1234;
    npronto = 0;
    confirma = 1'b0;
    tick(10);
    confirma = 1'b1;
    tick(8);
    chk("t4_idle_no_pronto", npronto, 32'd0);
    chk("t4_idle_numero", numero0, 32'h00000055);
    in = 1'b1;
    tick(10);
    chk("t4_still_wait_pronto", npronto, 32'd0);
    chk("t4_still_wait_aguard", {31'd0, aguard0}, 32'd1);
    chk("t4_still_wait_halt", {31'd0, halt0}, 32'd1);
    in = 1'b0;
    tick(1);

    // 5. back-to-back IN, button held
    chaves = 16'h00AA;
    in = 1'b1;
    tick(1);
    confirma = 1'b0;
    tick(6);
    chk("t5_pronto1", {31'd0, pronto0}, 32'd1);
    chk("t5_numero1", numero0, 32'h000000AA);
    tick(1);
    chk("t5_halt_second", {31'd0, halt0}, 32'd1);
    npronto = 0;
    tick(10);
    chk("t5_held_no_pronto", npronto, 32'd0);
    chk("t5_held_aguard", {31'd0, aguard0}, 32'd1);
    chaves = 16'h0007;
    confirma = 1'b1;
    tick(8);
    chk("t5_release_no_pronto", npronto, 32'd0);
    chk("t5_release_halt", {31'd0, halt0}, 32'd1);
    confirma = 1'b0;
    tick(5);
    chk("t5_pronto2_early", {31'd0, pronto0}, 32'd0);
    tick(1);
    chk("t5_pronto2", {31'd0, pronto0}, 32'd1);
    chk("t5_numero2", numero0, 32'h00000007);
    in = 1'b0;
    tick(1);
    confirma = 1'b1;
    tick(8);

    // 6. reset during ESPERA
    chaves = 16'h0099;
    in = 1'b1;
    tick(1);
    confirma = 1'b0;
    tick(3);
    npronto = 0;
    res = 1'b1;
    tick(1);
    chk("t6_rst_pronto", {31'd0, pronto0}, 32'd0);
    chk("t6_rst_numero", numero0, 32'h0);
    chk("t6_rst_aguard", {31'd0, aguard0}, 32'd0);
    chk("t6_rst_halt_in", {31'd0, halt0}, 32'd1);
    res = 1'b0; in = 1'b0;
    #1;
    chk("t6_halt_follow", {31'd0, halt0}, 32'd0);
    tick(10);
    chk("t6_no_pronto", npronto, 32'd0);
    chk("t6_numero_hold", numero0, 32'h0);
    confirma = 1'b1;
    tick(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
